// File: rtl/pcs_tx_encoder_if.sv
// CGMII-side input word and 66b coded output of the 64b/66b transmit encoder.
// The master drives the CGMII word and clock enable; the encoder answers on the slave side.
interface pcs_tx_encoder_if;
    logic        i_enable;
    logic [63:0] i_tx_data;
    logic [7:0]  i_tx_ctrl;
    logic [65:0] o_tx_coded;
    logic [3:0]  o_t_type;
    logic        o_tx_err;

    modport master (
        output i_enable, i_tx_data, i_tx_ctrl,
        input  o_tx_coded, o_t_type, o_tx_err
    );

    modport slave (
        input  i_enable, i_tx_data, i_tx_ctrl,
        output o_tx_coded, o_t_type, o_tx_err
    );
endinterface

// File: rtl/pcs_tx_encoder.sv
// 100GBASE-R 64b/66b transmit encoder: classifies the registered CGMII word, encodes it,
// and substitutes error blocks when the block sequence is illegal.
//   state   | meaning
//   TX_INIT | after reset, no block sent yet
//   TX_C    | last block was control / idle
//   TX_D    | inside a frame, last block was start or data
//   TX_T    | last block terminated a frame
//   TX_E    | last block was replaced by an error block
module pcs_tx_encoder (
    input  logic               i_clock,
    input  logic               i_reset,
    pcs_tx_encoder_if.slave    if_tx
);
    localparam int LEN_CODED_BLOCK = 66;
    localparam int LEN_TX_DATA     = 64;
    localparam int LEN_TX_CTRL     = 8;

    localparam logic [LEN_CODED_BLOCK-1:0] LBLOCK_T  = {2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0};
    localparam logic [LEN_CODED_BLOCK-1:0] EBLOCK_T  = {2'b10, 8'h1E, {8{7'h1E}}};
    localparam logic [LEN_TX_DATA-1:0]     IDLE_DATA = {8{8'h07}};
    localparam logic [LEN_TX_CTRL-1:0]     IDLE_CTRL = 8'hFF;

    localparam logic [3:0] TT_D = 4'b1000;
    localparam logic [3:0] TT_S = 4'b0100;
    localparam logic [3:0] TT_C = 4'b0010;
    localparam logic [3:0] TT_T = 4'b0001;
    localparam logic [3:0] TT_E = 4'b0000;

    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [LEN_TX_DATA-1:0]     r_tx_data;
    logic [LEN_TX_CTRL-1:0]     r_tx_ctrl;
    logic [LEN_CODED_BLOCK-1:0] r_tx_coded;
    logic [3:0]                 r_t_type;
    logic                       r_tx_err;

    logic [7:0]                 w_byte [8];
    logic [6:0]                 w_char7 [8];
    logic [7:0]                 w_char_ok;
    logic [48:0]                w_chars;
    logic [3:0]                 w_t_type;
    logic [LEN_CODED_BLOCK-1:0] w_block;
    logic [7:0]                 w_tail_mask;
    logic [55:0]                w_dmask;
    logic [48:0]                w_cmask;
    logic [55:0]                w_tpay;

    function automatic logic [7:0] t_block_type(input logic [2:0] n);
        case (n)
            3'd0:    t_block_type = 8'h87;
            3'd1:    t_block_type = 8'h99;
            3'd2:    t_block_type = 8'hAA;
            3'd3:    t_block_type = 8'hB4;
            3'd4:    t_block_type = 8'hCC;
            3'd5:    t_block_type = 8'hD2;
            3'd6:    t_block_type = 8'hE1;
            default: t_block_type = 8'hFF;
        endcase
    endfunction

    // w_char_ok uses the TXC orientation: bit 7 is lane 0
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_byte[k]        = r_tx_data[63-8*k -: 8];
            w_char_ok[7-k]   = (w_byte[k] == 8'h07) || (w_byte[k] == 8'hFE);
            w_char7[k]       = (w_byte[k] == 8'hFE) ? 7'h1E : 7'h00;
        end
        w_chars = {w_char7[1], w_char7[2], w_char7[3], w_char7[4], w_char7[5], w_char7[6], w_char7[7]};
    end

    always_comb begin
        w_t_type    = TT_E;
        w_block     = EBLOCK_T;
        w_tail_mask = '0;
        w_dmask     = '0;
        w_cmask     = '0;
        w_tpay      = '0;
        if (r_tx_ctrl == 8'h00) begin
            w_t_type = TT_D;
            w_block  = {2'b01, r_tx_data};
        end else if (r_tx_ctrl == 8'hFF && (&w_char_ok)) begin
            w_t_type = TT_C;
            w_block  = {2'b10, 8'h1E, w_char7[0], w_chars};
        end else if (r_tx_ctrl == 8'h80 && (w_byte[0] == 8'h9C || w_byte[0] == 8'h5C)) begin
            w_t_type = TT_C;
            w_block  = {2'b10, 8'h4B, r_tx_data[55:32], (w_byte[0] == 8'h5C) ? 4'hF : 4'h0, 28'h0};
        end else if (r_tx_ctrl == 8'h80 && w_byte[0] == 8'hFB) begin
            w_t_type = TT_S;
            w_block  = {2'b10, 8'h78, r_tx_data[55:0]};
        end else begin
            // Tn: data bytes left-justified, trailing control chars right-justified, zero gap between
            for (int n = 0; n < 8; n++) begin
                w_tail_mask = 8'hFF >> (n + 1);
                if (r_tx_ctrl == (8'hFF >> n) && w_byte[n] == 8'hFD &&
                    ((w_char_ok | ~w_tail_mask) == 8'hFF)) begin
                    w_dmask  = ~(56'hFF_FFFF_FFFF_FFFF >> (8 * n));
                    w_cmask  = 49'h1_FFFF_FFFF_FFFF >> (7 * n);
                    w_tpay   = (r_tx_data[63:8] & w_dmask) | {7'b0, w_chars & w_cmask};
                    w_t_type = TT_T;
                    w_block  = {2'b10, t_block_type(3'(n)), w_tpay};
                end
            end
        end
    end

    always_comb begin
        w_next = TX_E;
        case (r_state)
            TX_D: begin
                if (w_t_type == TT_D)      w_next = TX_D;
                else if (w_t_type == TT_T) w_next = TX_T;
            end
            TX_E: begin
                if (w_t_type == TT_D || w_t_type == TT_S) w_next = TX_D;
                else if (w_t_type == TT_C)                w_next = TX_C;
                else if (w_t_type == TT_T)                w_next = TX_T;
            end
            default: begin
                if (w_t_type == TT_C)      w_next = TX_C;
                else if (w_t_type == TT_S) w_next = TX_D;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_data  <= IDLE_DATA;
            r_tx_ctrl  <= IDLE_CTRL;
            r_state    <= TX_INIT;
            r_tx_coded <= LBLOCK_T;
            r_t_type   <= TT_E;
            r_tx_err   <= 1'b0;
        end else if (if_tx.i_enable) begin
            r_tx_data  <= if_tx.i_tx_data;
            r_tx_ctrl  <= if_tx.i_tx_ctrl;
            r_state    <= w_next;
            r_tx_coded <= (w_next == TX_E) ? EBLOCK_T : w_block;
            r_t_type   <= w_t_type;
            r_tx_err   <= (w_next == TX_E);
        end
    end

    assign if_tx.o_tx_coded = r_tx_coded;
    assign if_tx.o_t_type   = r_t_type;
    assign if_tx.o_tx_err   = r_tx_err;
endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Scoreboard bench for pcs_tx_encoder: directed CGMII words with hand-computed 66b blocks.
module tb_pcs_tx_encoder;
    typedef struct packed {
        logic [65:0] coded;
        logic [3:0]  ttype;
        logic        err;
    } exp_t;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [65:0] LBLOCK = {2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0};
    localparam logic [65:0] EBLOCK = {2'b10, 8'h1E, {8{7'h1E}}};
    localparam logic [65:0] C_IDLE = {2'b10, 8'h1E, 56'h0};
    localparam logic [3:0]  TD = 4'b1000, TS = 4'b0100, TC = 4'b0010, TT = 4'b0001, TE = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_fire = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    pcs_tx_encoder_if tx_if();

    pcs_tx_encoder dut (
        .i_clock (clk),
        .i_reset (rst),
        .if_tx   (tx_if)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) mon_fire <= tx_if.i_enable && !rst;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_fire) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h expected none", tx_if.o_tx_coded);
            end else begin
                e = sb.pop_front();
                check("coded", tx_if.o_tx_coded, e.coded);
                check("t_type", 66'(tx_if.o_t_type), 66'(e.ttype));
                check("tx_err", 66'(tx_if.o_tx_err), 66'(e.err));
                last_exp = e;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] c,
                        input logic [65:0] ec, input logic [3:0] et, input logic ee);
        exp_t e;
        tx_if.i_enable  = 1'b1;
        tx_if.i_tx_data = d;
        tx_if.i_tx_ctrl = c;
        e.coded = ec;
        e.ttype = et;
        e.err   = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle();
        send(IDLE_D, 8'hFF, C_IDLE, TC, 1'b0);
    endtask

    // The word driven on the last enabled edge before reset is discarded by the reset
    task automatic do_reset(input int cycles);
        exp_t e;
        rst = 1'b1;
        tx_if.i_enable  = 1'b1;
        tx_if.i_tx_data = 64'hDEADBEEF_CAFEF00D;
        tx_if.i_tx_ctrl = 8'h00;
        if (sb.size() > 0) void'(sb.pop_back());
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("reset_coded", tx_if.o_tx_coded, LBLOCK);
            check("reset_t_type", 66'(tx_if.o_t_type), 66'(TE));
            check("reset_err", 66'(tx_if.o_tx_err), 66'(1'b0));
        end
        rst = 1'b0;
        e.coded = C_IDLE;
        e.ttype = TC;
        e.err   = 1'b0;
        sb.push_back(e);
    endtask

    task automatic hold_disabled(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tx_if.i_enable  = 1'b0;
            tx_if.i_tx_data = 64'h0102030405060708 + 64'(i);
            tx_if.i_tx_ctrl = 8'(8'h3C + i);
            @(posedge clk);
            #1;
            check("frozen_coded", tx_if.o_tx_coded, last_exp.coded);
            check("frozen_err", 66'(tx_if.o_tx_err), 66'(last_exp.err));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        tx_if.i_enable  = 1'b0;
        tx_if.i_tx_data = '0;
        tx_if.i_tx_ctrl = '0;
        do_reset(2);

        repeat (4) send_idle();

        send(64'hFB555555555555D5, 8'h80, {2'b10, 8'h78, 56'h555555555555D5}, TS, 1'b0);
        send(64'h0011223344556677, 8'h00, {2'b01, 64'h0011223344556677}, TD, 1'b0);
        send(64'h8899AABBCCDDEEFF, 8'h00, {2'b01, 64'h8899AABBCCDDEEFF}, TD, 1'b0);
        send(64'hFFFFFFFFFFFFFFFF, 8'h00, {2'b01, 64'hFFFFFFFFFFFFFFFF}, TD, 1'b0);
        send(64'hAABBCCFD07070707, 8'h1F, {2'b10, 8'hB4, 56'hAABBCC00000000}, TT, 1'b0);
        send_idle();

        send(64'h0123456789ABCDEF, 8'h00, EBLOCK, TD, 1'b1);
        send_idle();

        send(64'h9C00000100000000, 8'h80, {2'b10, 8'h4B, 56'h00000100000000}, TC, 1'b0);
        send(64'h5C00000100000000, 8'h80, {2'b10, 8'h4B, 56'h000001F0000000}, TC, 1'b0);
        send(64'h07FE070707070707, 8'hFF, {2'b10, 8'h1E, 56'h00780000000000}, TC, 1'b0);
        send(64'h0707070700070707, 8'hFF, EBLOCK, TE, 1'b1);
        send(64'h0707070707070707, 8'h7F, EBLOCK, TE, 1'b1);
        send(64'hAB07070707070707, 8'h80, EBLOCK, TE, 1'b1);
        send_idle();

        send(64'hFB555555555555D5, 8'h80, {2'b10, 8'h78, 56'h555555555555D5}, TS, 1'b0);
        send(64'h11223344556677FD, 8'h01, {2'b10, 8'hFF, 56'h11223344556677}, TT, 1'b0);
        send_idle();

        send(64'hFB555555555555D5, 8'h80, {2'b10, 8'h78, 56'h555555555555D5}, TS, 1'b0);
        send(64'h1111111111111111, 8'h00, {2'b01, 64'h1111111111111111}, TD, 1'b0);
        hold_disabled(3);
        send(64'h2222222222222222, 8'h00, {2'b01, 64'h2222222222222222}, TD, 1'b0);
        send(64'hFDFE070707070707, 8'hFF, {2'b10, 8'h87, 56'h00780000000000}, TT, 1'b0);
        send_idle();

        send(64'hFB555555555555D5, 8'h80, {2'b10, 8'h78, 56'h555555555555D5}, TS, 1'b0);
        send(64'h3333333333333333, 8'h00, {2'b01, 64'h3333333333333333}, TD, 1'b0);
        send(64'h4444444444444444, 8'h00, {2'b01, 64'h4444444444444444}, TD, 1'b0);
        do_reset(1);
        send(64'h5555555555555555, 8'h00, EBLOCK, TD, 1'b1);
        send_idle();

        tx_if.i_enable  = 1'b1;
        tx_if.i_tx_data = IDLE_D;
        tx_if.i_tx_ctrl = 8'hFF;
        @(posedge clk);
        #1;
        tx_if.i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 66'(sb.size()), 66'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
